// File: rtl/reset_sequencer.sv
// Holds all reset domains, then releases them in index order, each gated on its synchronized ack.
// Outputs registered, one cycle after the state decision; a missing ack stalls a step for at most ACK_TIMEOUT cycles.
module reset_sequencer #(
    parameter int NUM_DOMAINS = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sw_rst_req,
    input  logic [NUM_DOMAINS-1:0] domain_ack,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   rst_busy,
    output logic                   rst_done,
    output logic [NUM_DOMAINS-1:0] timeout_err
);
    localparam int CNT_MAX = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int IW      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_WAIT_LOW,
        ST_RELEASE,
        ST_DONE,
        ST_IDLE
    } state_t;

    state_t                 state_q, state_nxt;
    logic [CW-1:0]          cnt_q, cnt_nxt, cnt_inc;
    logic [IW-1:0]          idx_q, idx_nxt;
    logic [NUM_DOMAINS-1:0] ack_meta, ack_sync;
    logic [NUM_DOMAINS-1:0] err_nxt, rst_n_nxt;
    logic                   busy_nxt, done_nxt;
    logic                   cnt_at_hold, cnt_at_timeout;

    assign cnt_inc        = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
    assign cnt_at_hold    = (cnt_q == CW'(HOLD_CYCLES - 1));
    assign cnt_at_timeout = (cnt_q == CW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_meta <= '0;
            ack_sync <= '0;
        end else begin
            ack_meta <= domain_ack;
            ack_sync <= ack_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_ASSERT;
            cnt_q        <= '0;
            idx_q        <= '0;
            domain_rst_n <= '0;
            rst_busy     <= 1'b1;
            rst_done     <= 1'b0;
            timeout_err  <= '0;
        end else begin
            state_q      <= state_nxt;
            cnt_q        <= cnt_nxt;
            idx_q        <= idx_nxt;
            domain_rst_n <= rst_n_nxt;
            rst_busy     <= busy_nxt;
            rst_done     <= done_nxt;
            timeout_err  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_inc;
        idx_nxt   = idx_q;
        err_nxt   = timeout_err;
        case (state_q)
            ST_ASSERT: begin
                if (cnt_at_hold) begin
                    state_nxt = ST_WAIT_LOW;
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT_LOW: begin
                // Acks still high at the deadline are flagged; with all acks low this OR is a no-op.
                if (ack_sync == '0 || cnt_at_timeout) begin
                    err_nxt   = timeout_err | ack_sync;
                    state_nxt = ST_RELEASE;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end
            end
            ST_RELEASE: begin
                if (sw_rst_req) begin
                    state_nxt = ST_ASSERT;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end else if (ack_sync[idx_q] || cnt_at_timeout) begin
                    if (!ack_sync[idx_q]) begin
                        err_nxt[idx_q] = 1'b1;
                    end
                    cnt_nxt = '0;
                    if (idx_q == IW'(NUM_DOMAINS - 1)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        idx_nxt = idx_q + IW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
            ST_IDLE: begin
                cnt_nxt = '0;
                if (sw_rst_req) begin
                    state_nxt = ST_ASSERT;
                end
            end
            default: begin
                state_nxt = ST_ASSERT;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register together with it.
    always_comb begin
        busy_nxt  = (state_nxt != ST_IDLE);
        done_nxt  = (state_nxt == ST_DONE);
        rst_n_nxt = '0;
        case (state_nxt)
            ST_RELEASE: begin
                for (int i = 0; i < NUM_DOMAINS; i++) begin
                    rst_n_nxt[i] = (idx_nxt >= IW'(i));
                end
            end
            ST_DONE, ST_IDLE: rst_n_nxt = '1;
            default: rst_n_nxt = '0;
        endcase
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: timed output vectors per scenario plus hand-built abort/async/stuck-ack sequences.
// Acks come from a two-cycle delay of domain_rst_n, with per-bit stuck-at overrides.
module tb_reset_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       sw_rst_req;
    logic [3:0] domain_ack;
    logic [3:0] domain_rst_n;
    logic       rst_busy;
    logic       rst_done;
    logic [3:0] timeout_err;

    logic [3:0] dly1, dly2;
    logic [3:0] force_lo, force_hi;
    int         edge_cnt = 0;
    int         done_cnt = 0;
    int         n_checks = 0;
    int         n_fail   = 0;

    typedef struct {
        int         scen;
        int         off;
        logic [3:0] rst_n;
        logic       busy;
        logic       done;
        logic [3:0] err;
    } vec_t;

    vec_t tbl[$];

    reset_sequencer #(
        .NUM_DOMAINS(4),
        .HOLD_CYCLES(16),
        .ACK_TIMEOUT(64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw_rst_req  (sw_rst_req),
        .domain_ack  (domain_ack),
        .domain_rst_n(domain_rst_n),
        .rst_busy    (rst_busy),
        .rst_done    (rst_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) if (rst_done === 1'b1) done_cnt <= done_cnt + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dly1 <= '0;
            dly2 <= '0;
        end else begin
            dly1 <= domain_rst_n;
            dly2 <= dly1;
        end
    end

    assign domain_ack = (dly2 | force_hi) & ~force_lo;

    task automatic add(input int scen, input int off, input logic [3:0] rn,
                       input logic busy, input logic done, input logic [3:0] err);
        vec_t v;
        v.scen = scen; v.off = off; v.rst_n = rn; v.busy = busy; v.done = done; v.err = err;
        tbl.push_back(v);
    endtask

    task automatic check_vec(input string name, input int off, input logic [3:0] e_rn,
                             input logic e_busy, input logic e_done, input logic [3:0] e_err);
        n_checks++;
        if (domain_rst_n !== e_rn || rst_busy !== e_busy || rst_done !== e_done || timeout_err !== e_err) begin
            n_fail++;
            $display("FAIL %s @+%0d: got rst_n=%b busy=%b done=%b err=%b, expected rst_n=%b busy=%b done=%b err=%b",
                     name, off, domain_rst_n, rst_busy, rst_done, timeout_err, e_rn, e_busy, e_done, e_err);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Offsets count rising edges after the base edge; each vector is sampled on the following falling edge.
    task automatic play(input int scen, input int base, input logic [3:0] err_base, input string name);
        for (int k = 0; k < tbl.size(); k++) begin
            if (tbl[k].scen == scen) begin
                while (edge_cnt < base + tbl[k].off) @(negedge clk);
                check_vec(name, tbl[k].off, tbl[k].rst_n, tbl[k].busy, tbl[k].done, tbl[k].err | err_base);
            end
        end
    endtask

    task automatic do_sw(output int base);
        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
        base = edge_cnt;
    endtask

    initial begin
        int base;
        int d0;

        // Scenario 0: nominal sequence, bits released at 17/22/27/32, DONE at 37, IDLE at 38.
        add(0,  0, 4'b0000, 1, 0, 4'b0000);
        add(0,  1, 4'b0000, 1, 0, 4'b0000);
        add(0, 16, 4'b0000, 1, 0, 4'b0000);
        add(0, 17, 4'b0001, 1, 0, 4'b0000);
        add(0, 21, 4'b0001, 1, 0, 4'b0000);
        add(0, 22, 4'b0011, 1, 0, 4'b0000);
        add(0, 27, 4'b0111, 1, 0, 4'b0000);
        add(0, 32, 4'b1111, 1, 0, 4'b0000);
        add(0, 36, 4'b1111, 1, 0, 4'b0000);
        add(0, 37, 4'b1111, 1, 1, 4'b0000);
        add(0, 38, 4'b1111, 0, 0, 4'b0000);
        // Scenario 1: ack[2] stuck low, 64-cycle wait from edge 28 expires at edge 91.
        add(1,  0, 4'b0000, 1, 0, 4'b0000);
        add(1, 27, 4'b0111, 1, 0, 4'b0000);
        add(1, 90, 4'b0111, 1, 0, 4'b0000);
        add(1, 91, 4'b1111, 1, 0, 4'b0100);
        add(1, 95, 4'b1111, 1, 0, 4'b0100);
        add(1, 96, 4'b1111, 1, 1, 4'b0100);
        add(1, 97, 4'b1111, 0, 0, 4'b0100);
        // Scenario 2: ack[1] stuck high, WAIT_LOW times out at edge 80.
        add(2,  0, 4'b0000, 1, 0, 4'b0000);
        add(2, 17, 4'b0000, 1, 0, 4'b0000);
        add(2, 79, 4'b0000, 1, 0, 4'b0000);
        add(2, 80, 4'b0001, 1, 0, 4'b0010);
        add(2, 85, 4'b0011, 1, 0, 4'b0010);
        add(2, 86, 4'b0111, 1, 0, 4'b0010);
        add(2, 91, 4'b1111, 1, 0, 4'b0010);
        add(2, 96, 4'b1111, 1, 1, 4'b0010);
        add(2, 97, 4'b1111, 0, 0, 4'b0010);
        // Scenario 3: prefix up to idx 1 waiting in RELEASE.
        add(3,  0, 4'b0000, 1, 0, 4'b0000);
        add(3, 17, 4'b0001, 1, 0, 4'b0000);
        add(3, 22, 4'b0011, 1, 0, 4'b0000);
        add(3, 23, 4'b0011, 1, 0, 4'b0000);

        rst = 1'b1; sw_rst_req = 1'b0; force_lo = '0; force_hi = '0;
        repeat (3) @(negedge clk);
        check_vec("reset_hold", 0, 4'b0000, 1, 0, 4'b0000);

        d0 = done_cnt;
        rst = 1'b0; base = edge_cnt;
        play(0, base, 4'b0000, "power_on");
        check_int("power_on_done_pulses", done_cnt - d0, 1);

        d0 = done_cnt;
        do_sw(base);
        play(0, base, 4'b0000, "sw_reseq");
        check_int("sw_reseq_done_pulses", done_cnt - d0, 1);

        d0 = done_cnt;
        do_sw(base);
        play(3, base, 4'b0000, "abort_pre");
        do_sw(base);
        play(0, base, 4'b0000, "abort_restart");
        check_int("abort_done_pulses", done_cnt - d0, 1);

        force_lo = 4'b0100;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        rst = 1'b0; base = edge_cnt;
        play(1, base, 4'b0000, "stuck_low");
        check_int("stuck_low_done_pulses", done_cnt - d0, 1);
        force_lo = '0;
        do_sw(base);
        play(0, base, 4'b0100, "sticky_reseq");

        rst = 1'b1; force_hi = 4'b0010;
        repeat (2) @(negedge clk);
        check_vec("rst_clears_err", 0, 4'b0000, 1, 0, 4'b0000);
        d0 = done_cnt;
        rst = 1'b0; base = edge_cnt;
        play(2, base, 4'b0000, "stuck_high");
        check_int("stuck_high_done_pulses", done_cnt - d0, 1);
        force_hi = '0;

        do_sw(base);
        play(3, base, 4'b0010, "async_pre");
        @(negedge clk);
        check_vec("async_pre_edge24", 24, 4'b0011, 1, 0, 4'b0010);
        #1 rst = 1'b1;
        #1 check_vec("async_rst_immediate", 24, 4'b0000, 1, 0, 4'b0000);
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        rst = 1'b0; base = edge_cnt;
        play(0, base, 4'b0000, "async_restart");
        check_int("async_restart_done_pulses", done_cnt - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
